// File: rtl/req_ack_4phase_responder.sv
// ---------------------------------------------------------------------------
// req_ack_4phase_responder
//
// Responder side of a 4-phase req/ack handshake. The initiator's req arrives
// asynchronously to clk2 and is synchronized before use. An accepted request
// is forwarded downstream as a valid/ready command. The responder then waits
// for a valid/ready response and returns that response to the initiator
// together with ack. ack is held until req is seen low again.
//
// Ports
//   clk2, rst2_n         sole clock; async active-low reset (sync release)
//   req, req_data        4-phase request + payload (req async to clk2)
//   ack, ack_data        registered acknowledge + response payload
//   cmd_valid/ready/data downstream command channel (cmd_data registered)
//   rsp_valid/ready/data downstream response channel
//   busy                 FSM not in IDLE
//   proto_err            sticky: req dropped before ack was given
// ---------------------------------------------------------------------------
module req_ack_4phase_responder #(
    parameter int DWIDTH      = 8,
    parameter int RWIDTH      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk2,
    input  logic              rst2_n,
    input  logic              req,
    input  logic [DWIDTH-1:0] req_data,
    output logic              ack,
    output logic [RWIDTH-1:0] ack_data,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [DWIDTH-1:0] cmd_data,
    input  logic              rsp_valid,
    output logic              rsp_ready,
    input  logic [RWIDTH-1:0] rsp_data,
    output logic              busy,
    output logic              proto_err
);

    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
            $error("SYNC_STAGES must be in 2..4");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_RSP  = 2'd2,
        ST_ACK  = 2'd3
    } state_t;

    // -----------------------------------------------------------------------
    // req synchronizer. This is the only place req is sampled.
    // r_sync_vld shifts in ones alongside the data chain. It marks when the
    // chain output holds a real sample of req rather than the reset zeros.
    // Without it, those zeros would look like "req seen low" and would arm
    // the responder. A req that was already high at reset would then be
    // accepted.
    // -----------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_req_sync;
    logic [SYNC_STAGES-1:0] r_sync_vld;
    logic                   w_req_s;
    logic                   w_req_s_vld;

    always_ff @(posedge clk2 or negedge rst2_n) begin
        if (!rst2_n) begin
            r_req_sync <= '0;
            r_sync_vld <= '0;
        end else begin
            r_req_sync <= {r_req_sync[SYNC_STAGES-2:0], req};
            r_sync_vld <= {r_sync_vld[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign w_req_s     = r_req_sync[SYNC_STAGES-1];
    assign w_req_s_vld = r_sync_vld[SYNC_STAGES-1];

    // -----------------------------------------------------------------------
    // armed: set once req_s has genuinely been observed low. In normal
    // operation ACK only exits on req_s=0, so armed only gates the first
    // request after reset.
    // -----------------------------------------------------------------------
    logic r_armed;

    always_ff @(posedge clk2 or negedge rst2_n) begin
        if (!rst2_n) begin
            r_armed <= 1'b0;
        end else if (w_req_s_vld && !w_req_s) begin
            r_armed <= 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    state_t r_state;
    state_t w_state_nxt;
    logic   w_accept;     // IDLE -> CMD: capture req_data
    logic   w_cmd_hs;     // CMD  -> RSP: command handshake
    logic   w_rsp_hs;     // RSP  -> ACK: response handshake, capture rsp_data
    logic   w_ack_done;   // ACK  -> IDLE: req_s seen low

    always_ff @(posedge clk2 or negedge rst2_n) begin
        if (!rst2_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_cmd_hs    = 1'b0;
        w_rsp_hs    = 1'b0;
        w_ack_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req_s && r_armed) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_CMD;
                end
            end
            ST_CMD: begin
                if (cmd_valid && cmd_ready) begin
                    w_cmd_hs    = 1'b1;
                    w_state_nxt = ST_RSP;
                end
            end
            ST_RSP: begin
                if (rsp_valid && rsp_ready) begin
                    w_rsp_hs    = 1'b1;
                    w_state_nxt = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!w_req_s) begin
                    w_ack_done  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registered outputs. Each has its own flop so that ack stays glitch-free
    // even though the state encoding changes two bits on some transitions.
    // -----------------------------------------------------------------------
    logic              r_cmd_valid;
    logic [DWIDTH-1:0] r_cmd_data;
    logic              r_ack;
    logic [RWIDTH-1:0] r_ack_data;
    logic              r_proto_err;

    always_ff @(posedge clk2 or negedge rst2_n) begin
        if (!rst2_n) begin
            r_cmd_valid <= 1'b0;
            r_cmd_data  <= '0;
        end else begin
            if (w_accept) begin
                r_cmd_valid <= 1'b1;
                r_cmd_data  <= req_data;
            end else if (w_cmd_hs) begin
                r_cmd_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk2 or negedge rst2_n) begin
        if (!rst2_n) begin
            r_ack      <= 1'b0;
            r_ack_data <= '0;
        end else begin
            if (w_rsp_hs) begin
                r_ack      <= 1'b1;
                r_ack_data <= rsp_data;
            end else if (w_ack_done) begin
                r_ack      <= 1'b0;
            end
        end
    end

    // If req drops while the command or response is still outstanding, the
    // initiator broke the protocol. The transaction still runs to completion
    // so the downstream side never sees a half-finished exchange.
    always_ff @(posedge clk2 or negedge rst2_n) begin
        if (!rst2_n) begin
            r_proto_err <= 1'b0;
        end else if ((r_state == ST_CMD || r_state == ST_RSP) && !w_req_s) begin
            r_proto_err <= 1'b1;
        end
    end

    assign cmd_valid = r_cmd_valid;
    assign cmd_data  = r_cmd_data;
    assign ack       = r_ack;
    assign ack_data  = r_ack_data;
    assign proto_err = r_proto_err;
    assign rsp_ready = (r_state == ST_RSP);
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_req_ack_4phase_responder.sv
module tb_req_ack_4phase_responder;
    localparam int DW   = 8;
    localparam int RW   = 8;
    localparam int SYNC = 2;

    logic          clk2 = 1'b0;
    logic          rst2_n;
    logic          req;
    logic [DW-1:0] req_data;
    logic          ack;
    logic [RW-1:0] ack_data;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [DW-1:0] cmd_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [RW-1:0] rsp_data;
    logic          busy;
    logic          proto_err;

    req_ack_4phase_responder #(.DWIDTH(DW), .RWIDTH(RW), .SYNC_STAGES(SYNC)) dut (
        .clk2(clk2), .rst2_n(rst2_n), .req(req), .req_data(req_data),
        .ack(ack), .ack_data(ack_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .busy(busy), .proto_err(proto_err)
    );

    always #5 clk2 = ~clk2;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference model, transaction level. It keeps a short history of req
    // samples, a flag for "req seen low since reset", and where the current
    // transaction stands (command outstanding / awaiting response / acked).
    // ---------------------------------------------------------------------
    bit          m_hist[$];
    bit          m_armed    = 0;
    bit          m_cmd_out  = 0;
    bit          m_rsp_wait = 0;
    bit          m_acked    = 0;
    bit          m_err      = 0;
    logic [7:0]  m_cmd_d    = '0;
    logic [7:0]  m_ack_d    = '0;
    bit          m_real;
    bit          m_rs;

    always @(posedge clk2 or negedge rst2_n) begin
        if (!rst2_n) begin
            m_hist.delete();
            m_armed = 0; m_cmd_out = 0; m_rsp_wait = 0; m_acked = 0; m_err = 0;
            m_cmd_d = '0; m_ack_d = '0;
        end else begin
            // Sampled req is valid only after SYNC clock edges of history.
            m_real = (m_hist.size() >= SYNC);
            m_rs   = m_real ? m_hist[SYNC-1] : 1'b0;
            if (m_cmd_out) begin
                if (!m_rs) m_err = 1;
                if (cmd_ready) begin m_cmd_out = 0; m_rsp_wait = 1; end
            end else if (m_rsp_wait) begin
                if (!m_rs) m_err = 1;
                if (rsp_valid) begin m_rsp_wait = 0; m_acked = 1; m_ack_d = rsp_data; end
            end else if (m_acked) begin
                if (!m_rs) m_acked = 0;
            end else if (m_rs && m_armed) begin
                m_cmd_out = 1; m_cmd_d = req_data;
            end
            if (m_real && !m_rs) m_armed = 1;
            m_hist.push_front(req);
            if (m_hist.size() > SYNC) void'(m_hist.pop_back());
        end
    end

    // Every-cycle compare against the model
    always @(negedge clk2) begin
        chk("cmp_ack",       ack,       m_acked);
        chk("cmp_ack_data",  ack_data,  m_ack_d);
        chk("cmp_cmd_valid", cmd_valid, m_cmd_out);
        chk("cmp_cmd_data",  cmd_data,  m_cmd_d);
        chk("cmp_rsp_ready", rsp_ready, m_rsp_wait);
        chk("cmp_busy",      busy,      m_cmd_out | m_rsp_wait | m_acked);
        chk("cmp_proto_err", proto_err, m_err);
    end

    // Handshake monitor for the back-to-back sequence
    bit         mon_en = 0;
    logic [7:0] hs_q[$];
    int         ack_rises = 0;
    logic       ack_prev = 1'b0;
    always @(negedge clk2) begin
        if (mon_en) begin
            if (cmd_valid && cmd_ready) hs_q.push_back(cmd_data);
            if (ack && !ack_prev) ack_rises++;
        end
        ack_prev = ack;
    end

    bit rand_ds = 0;

    task automatic tick();
        @(posedge clk2);
        #2;
        if (rand_ds) begin
            cmd_ready = ($urandom_range(0, 3) != 0);
            rsp_valid = ($urandom_range(0, 2) == 0);
            rsp_data  = 8'($urandom);
        end
    endtask

    task automatic wait_ack(input logic v, input int budget, input string name);
        int n = 0;
        while (ack !== v && n < budget) begin
            tick();
            n++;
        end
        chk(name, ack, v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst2_n = 1'b0; req = 1'b0; req_data = '0;
        cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
        repeat (3) tick();
        chk("rst_ack", ack, 0);
        chk("rst_ack_data", ack_data, 0);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_cmd_data", cmd_data, 0);
        chk("rst_rsp_ready", rsp_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_proto_err", proto_err, 0);
        rst2_n = 1'b1;
        repeat (4) tick();

        // Single transfer with literal latencies
        cmd_ready = 1; rsp_valid = 1; rsp_data = 8'h5A; req_data = 8'hA5; req = 1;
        tick(); chk("lat_cv_e1", cmd_valid, 0);
        tick(); chk("lat_cv_e2", cmd_valid, 0);
        tick(); chk("lat_cv_e3", cmd_valid, 1);
        chk("single_cmd_data", cmd_data, 8'hA5);
        tick(); tick();
        chk("single_ack", ack, 1);
        chk("single_ack_data", ack_data, 8'h5A);
        req = 0;
        tick(); tick(); chk("ackfall_e2", ack, 1);
        tick(); chk("ackfall_e3", ack, 0);
        chk("single_idle", busy, 0);
        tick(); tick();

        // Back-pressure
        cmd_ready = 0; rsp_valid = 0; req_data = 8'h3C; req = 1;
        repeat (3) tick();
        chk("bp_cmd_valid", cmd_valid, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_cmd_hold", cmd_data, 8'h3C);
            chk("bp_cmd_valid_hold", cmd_valid, 1);
            chk("bp_ack_low", ack, 0);
        end
        cmd_ready = 1; tick(); cmd_ready = 0;
        chk("bp_cmd_done", cmd_valid, 0);
        chk("bp_rsp_ready", rsp_ready, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_rsp_wait_ready", rsp_ready, 1);
            chk("bp_rsp_wait_ack", ack, 0);
        end
        rsp_valid = 1; rsp_data = 8'hC3; tick(); rsp_valid = 0;
        chk("bp_ack_rise", ack, 1);
        chk("bp_ack_data", ack_data, 8'hC3);
        chk("bp_rsp_ready_off", rsp_ready, 0);
        req = 0;
        wait_ack(0, 10, "bp_ack_fall");
        tick(); tick();

        // Stray responses in IDLE and CMD
        rsp_valid = 1; rsp_data = 8'hFF;
        repeat (3) tick();
        chk("stray_idle_rdy", rsp_ready, 0);
        chk("stray_idle_data", ack_data, 8'hC3);
        chk("stray_idle_ack", ack, 0);
        req_data = 8'h44; req = 1; cmd_ready = 0;
        repeat (3) tick();
        chk("stray_cmd_valid", cmd_valid, 1);
        repeat (3) tick();
        chk("stray_cmd_rdy", rsp_ready, 0);
        chk("stray_cmd_data", ack_data, 8'hC3);
        cmd_ready = 1; tick(); cmd_ready = 0;
        tick(); rsp_valid = 0;
        chk("stray_final_ack", ack, 1);
        chk("stray_final_data", ack_data, 8'hFF);
        req = 0;
        wait_ack(0, 10, "stray_ack_fall");
        tick();

        // Back-to-back
        hs_q.delete(); ack_rises = 0; mon_en = 1;
        cmd_ready = 1; rsp_valid = 1; rsp_data = 8'h99;
        for (int i = 1; i <= 4; i++) begin
            req_data = 8'(i); req = 1;
            wait_ack(1, 20, "b2b_ack_rise");
            req = 0;
            wait_ack(0, 20, "b2b_ack_fall");
        end
        tick(); mon_en = 0;
        chk("b2b_hs_count", hs_q.size(), 4);
        for (int i = 0; i < 4 && i < hs_q.size(); i++) chk("b2b_hs_order", hs_q[i], i + 1);
        chk("b2b_ack_rises", ack_rises, 4);

        // Early req drop
        cmd_ready = 0; rsp_valid = 0; req_data = 8'h77; req = 1;
        repeat (3) tick();
        chk("early_cmd_valid", cmd_valid, 1);
        chk("early_err_before", proto_err, 0);
        req = 0;
        repeat (3) tick();
        chk("early_err_set", proto_err, 1);
        chk("early_cmd_still", cmd_valid, 1);
        cmd_ready = 1; tick(); cmd_ready = 0;
        rsp_valid = 1; rsp_data = 8'h88; tick(); rsp_valid = 0;
        chk("early_ack", ack, 1);
        chk("early_ack_data", ack_data, 8'h88);
        tick();
        chk("early_ack_fall", ack, 0);
        repeat (5) tick();
        chk("early_err_sticky", proto_err, 1);

        // Reset mid-ACK with req held high
        req_data = 8'h55; cmd_ready = 1; rsp_valid = 1; rsp_data = 8'hAA; req = 1;
        wait_ack(1, 20, "rstack_ack_rise");
        rst2_n = 0;
        #1;
        chk("rstack_ack_async", ack, 0);
        chk("rstack_busy", busy, 0);
        chk("rstack_err_clr", proto_err, 0);
        chk("rstack_ack_data", ack_data, 0);
        tick(); rst2_n = 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("rstack_no_stale", busy, 0);
        end
        req = 0;
        repeat (4) tick();
        req = 1;
        wait_ack(1, 20, "rstack_new_ack");
        chk("rstack_new_data", ack_data, 8'hAA);
        req = 0;
        wait_ack(0, 20, "rstack_new_fall");
        tick();

        // Randomized transactions, well-behaved initiator
        rand_ds = 1;
        for (int t = 0; t < 40; t++) begin
            req_data = 8'($urandom); req = 1;
            wait_ack(1, 300, "rnd_ack_rise");
            repeat ($urandom_range(0, 3)) tick();
            req = 0;
            wait_ack(0, 50, "rnd_ack_fall");
            repeat ($urandom_range(0, 3)) tick();
        end
        rand_ds = 0; cmd_ready = 0; rsp_valid = 0;
        repeat (3) tick();
        chk("rnd_err_clean", proto_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
